// File: rtl/decode_pkg.sv
// Shared decode definitions: instruction group encodings, field widths and
// the issue skid-buffer state encoding.
package decode_pkg;

    localparam logic [1:0] GRP_ILL = 2'b00;
    localparam logic [1:0] GRP_RI  = 2'b01;
    localparam logic [1:0] GRP_SB  = 2'b10;
    localparam logic [1:0] GRP_UJ  = 2'b11;

    localparam int IMM_W = 21;
    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_e;

endpackage

// File: rtl/imm_widen.sv
// Widens the unified 21-bit decode immediate to XLEN according to the
// instruction group/specifier; shared with the branch-target adder.
module imm_widen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]       grp,
    input  logic             spec,
    input  logic [IMM_W-1:0] imm,
    output logic [XLEN-1:0]  imm_wide,
    output logic             has_imm
);

    logic [XLEN-1:0] sext_s;
    logic [XLEN-1:0] upper_s;

    // Upstream already replicated the 12-bit sign into bit 20, so I/S/B/J share one extension.
    assign sext_s  = XLEN'($signed(imm));
    assign upper_s = XLEN'($signed({imm[19:0], 12'h000}));

    // Format select; R-type and illegal carry no immediate.
    always_comb begin
        imm_wide = '0;
        has_imm  = 1'b0;
        case (grp)
            GRP_RI: begin
                if (spec) begin
                    imm_wide = sext_s;
                    has_imm  = 1'b1;
                end else begin
                    imm_wide = '0;
                    has_imm  = 1'b0;
                end
            end
            GRP_SB: begin
                imm_wide = sext_s;
                has_imm  = 1'b1;
            end
            GRP_UJ: begin
                if (spec) begin
                    imm_wide = sext_s;
                end else begin
                    imm_wide = upper_s;
                end
                has_imm = 1'b1;
            end
            default: begin
                imm_wide = '0;
                has_imm  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/decode_issue_reg.sv
// Registered decode output stage: resolves rd, widens the immediate and holds
// results in a 2-entry skid buffer with a valid/ready handshake to execute.
module decode_issue_reg
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_group,
    input  logic             in_specifier,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [REG_W-1:0] in_rs1,
    input  logic [REG_W-1:0] in_rs2,
    input  logic [REG_W-1:0] in_rd,
    input  logic [REG_W-1:0] in_uj_rd,
    input  logic [IMM_W-1:0] in_imm,
    input  logic             in_use_uj_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_group,
    output logic             out_specifier,
    output logic [XLEN-1:0]  out_pc,
    output logic [REG_W-1:0] out_rs1,
    output logic [REG_W-1:0] out_rs2,
    output logic [REG_W-1:0] out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_has_imm,
    output logic             out_illegal
);

    localparam int ENTRY_W = 2 + 1 + XLEN + 3 * REG_W + XLEN + 1 + 1;

    skid_state_e        state_r;
    skid_state_e        state_next_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [ENTRY_W-1:0] main_r;
    logic [ENTRY_W-1:0] skid_r;
    logic [ENTRY_W-1:0] entry_s;
    logic [XLEN-1:0]    imm_wide_s;
    logic               has_imm_s;
    logic [REG_W-1:0]   rd_s;
    logic               accept_s;
    logic               pop_s;
    logic               load_main_in_s;
    logic               load_main_skid_s;
    logic               load_skid_s;

    imm_widen #(.XLEN(XLEN)) u_imm_widen (
        .grp      (in_group),
        .spec     (in_specifier),
        .imm      (in_imm),
        .imm_wide (imm_wide_s),
        .has_imm  (has_imm_s)
    );

    assign rd_s     = in_use_uj_rd ? in_uj_rd : in_rd;
    assign entry_s  = {in_group, in_specifier, in_pc, in_rs1, in_rs2, rd_s,
                       imm_wide_s, has_imm_s, (in_group == GRP_ILL)};
    assign accept_s = in_valid & in_ready_r;
    assign pop_s    = out_valid_r & out_ready;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign {out_group, out_specifier, out_pc, out_rs1, out_rs2, out_rd,
            out_imm, out_has_imm, out_illegal} = main_r;

    // Next-state and register-load selection; flush discards everything including a same-cycle accept.
    always_comb begin
        state_next_s     = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        case (state_r)
            SKID_EMPTY: begin
                if (accept_s) begin
                    state_next_s   = SKID_ONE;
                    load_main_in_s = 1'b1;
                end else begin
                    state_next_s = SKID_EMPTY;
                end
            end
            SKID_ONE: begin
                if (accept_s && pop_s) begin
                    state_next_s   = SKID_ONE;
                    load_main_in_s = 1'b1;
                end else if (accept_s) begin
                    state_next_s = SKID_FULL;
                    load_skid_s  = 1'b1;
                end else if (pop_s) begin
                    state_next_s = SKID_EMPTY;
                end else begin
                    state_next_s = SKID_ONE;
                end
            end
            SKID_FULL: begin
                if (pop_s) begin
                    state_next_s     = SKID_ONE;
                    load_main_skid_s = 1'b1;
                end else begin
                    state_next_s = SKID_FULL;
                end
            end
            default: begin
                state_next_s = SKID_EMPTY;
            end
        endcase
        if (flush) begin
            state_next_s     = SKID_EMPTY;
            load_main_in_s   = 1'b0;
            load_main_skid_s = 1'b0;
            load_skid_s      = 1'b0;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // State plus handshake flags registered from the next state so neither has a combinational input path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= SKID_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s != SKID_FULL);
            out_valid_r <= (state_next_s != SKID_EMPTY);
        end
    end

    // Main entry register; only the has_imm/illegal flags are reset, payload is don't-care while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_r[1:0] <= 2'b00;
        end else if (load_main_in_s) begin
            main_r <= entry_s;
        end else if (load_main_skid_s) begin
            main_r <= skid_r;
        end else begin
            main_r <= main_r;
        end
    end

    // Skid entry register, filled only when execute stalls with main occupied.
    always_ff @(posedge clk) begin
        if (load_skid_s) begin
            skid_r <= entry_s;
        end else begin
            skid_r <= skid_r;
        end
    end

endmodule

// File: tb/tb_decode_issue_reg.sv
// Randomised and directed bench for decode_issue_reg against a queue-based
// reference model of the 2-entry issue buffer.
module tb_decode_issue_reg;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_group;
    logic        in_specifier;
    logic [31:0] in_pc;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic [4:0]  in_uj_rd;
    logic [20:0] in_imm;
    logic        in_use_uj_rd;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_group;
    logic        out_specifier;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic        out_has_imm;
    logic        out_illegal;

    typedef struct {
        logic [1:0]  grp;
        logic        spec;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        has_imm;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    logic last_acc;

    decode_issue_reg #(.XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_group      (in_group),
        .in_specifier  (in_specifier),
        .in_pc         (in_pc),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_rd         (in_rd),
        .in_uj_rd      (in_uj_rd),
        .in_imm        (in_imm),
        .in_use_uj_rd  (in_use_uj_rd),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_group     (out_group),
        .out_specifier (out_specifier),
        .out_pc        (out_pc),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_rd        (out_rd),
        .out_imm       (out_imm),
        .out_has_imm   (out_has_imm),
        .out_illegal   (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Immediate value as a signed number following the format rules, not the bit layout.
    function automatic logic [31:0] ref_imm(input logic [1:0] g, input logic s, input logic [20:0] imm);
        int          v;
        logic [31:0] upper;
        v = (imm >= 21'h100000) ? (int'(imm) - 2097152) : int'(imm);
        upper = 32'(imm[19:0]);
        if (g == 2'b00) return 32'd0;
        if (g == 2'b01 && !s) return 32'd0;
        if (g == 2'b11 && !s) return upper * 32'd4096;
        return 32'(v);
    endfunction

    function automatic exp_t make_exp();
        exp_t e;
        e.grp     = in_group;
        e.spec    = in_specifier;
        e.pc      = in_pc;
        e.rs1     = in_rs1;
        e.rs2     = in_rs2;
        e.rd      = in_use_uj_rd ? in_uj_rd : in_rd;
        e.imm     = ref_imm(in_group, in_specifier, in_imm);
        e.has_imm = !(in_group == 2'b00 || (in_group == 2'b01 && !in_specifier));
        e.ill     = (in_group == 2'b00);
        return e;
    endfunction

    // One clock: compare outputs mid-cycle, then advance the model on the rising edge.
    task automatic step();
        exp_t e;
        logic acc;
        logic pp;
        @(negedge clk);
        check_eq("in_ready", 32'(in_ready), 32'(q.size() < 2));
        check_eq("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check_eq("out_group", 32'(out_group), 32'(q[0].grp));
            check_eq("out_spec", 32'(out_specifier), 32'(q[0].spec));
            check_eq("out_pc", out_pc, q[0].pc);
            check_eq("out_rs1", 32'(out_rs1), 32'(q[0].rs1));
            check_eq("out_rs2", 32'(out_rs2), 32'(q[0].rs2));
            check_eq("out_rd", 32'(out_rd), 32'(q[0].rd));
            check_eq("out_imm", out_imm, q[0].imm);
            check_eq("out_has_imm", 32'(out_has_imm), 32'(q[0].has_imm));
            check_eq("out_illegal", 32'(out_illegal), 32'(q[0].ill));
        end
        acc = in_valid && (q.size() < 2);
        pp  = (q.size() != 0) && out_ready;
        e   = make_exp();
        @(posedge clk);
        last_acc = 1'b0;
        if (rst || flush) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) begin
                q.push_back(e);
                last_acc = 1'b1;
            end
        end
        #1;
    endtask

    task automatic drive(input logic [1:0] g, input logic s, input logic [31:0] pc,
                         input logic [20:0] imm, input logic [4:0] rd,
                         input logic use_uj, input logic [4:0] uj_rd);
        in_valid     = 1'b1;
        in_group     = g;
        in_specifier = s;
        in_pc        = pc;
        in_imm       = imm;
        in_rd        = rd;
        in_use_uj_rd = use_uj;
        in_uj_rd     = uj_rd;
        in_rs1       = pc[4:0];
        in_rs2       = pc[9:5];
    endtask

    // Hold the current offer until the model says it was taken, bounded.
    task automatic push_until_accepted();
        int n;
        n = 0;
        step();
        while (!last_acc && n < 10) begin
            step();
            n++;
        end
        check_eq("accept_bound", 32'(last_acc), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0; last_acc = 1'b0;
        in_valid = 1'b0; in_group = 2'b01; in_specifier = 1'b0; in_pc = 32'd0;
        in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0; in_uj_rd = 5'd0;
        in_imm = 21'd0; in_use_uj_rd = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("rst_out_illegal", 32'(out_illegal), 32'd0);
        check_eq("rst_out_has_imm", 32'(out_has_imm), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        out_ready = 1'b1;

        // I-type, -1
        drive(2'b01, 1'b1, 32'h0000_1000, 21'h1FFFFF, 5'd7, 1'b0, 5'd0);
        step();
        check_eq("itype_valid", 32'(out_valid), 32'd1);
        check_eq("itype_imm", out_imm, 32'hFFFF_FFFF);
        check_eq("itype_rd", 32'(out_rd), 32'd7);
        check_eq("itype_has_imm", 32'(out_has_imm), 32'd1);
        // U-type with uj rd
        drive(2'b11, 1'b0, 32'h0000_1004, 21'h0ABCDE, 5'd9, 1'b1, 5'd3);
        step();
        check_eq("utype_imm", out_imm, 32'hABCD_E000);
        check_eq("utype_rd", 32'(out_rd), 32'd3);
        // J-type negative
        drive(2'b11, 1'b1, 32'h0000_1008, 21'h100000, 5'd1, 1'b1, 5'd1);
        step();
        check_eq("jtype_imm", out_imm, 32'hFFF0_0000);
        // R-type
        drive(2'b01, 1'b0, 32'h0000_100C, 21'h012345, 5'd4, 1'b0, 5'd0);
        step();
        check_eq("rtype_imm", out_imm, 32'd0);
        check_eq("rtype_has_imm", 32'(out_has_imm), 32'd0);
        // illegal group
        drive(2'b00, 1'b1, 32'h0000_1010, 21'h1F0F0F, 5'd5, 1'b0, 5'd0);
        step();
        check_eq("illegal_flag", 32'(out_illegal), 32'd1);
        check_eq("illegal_imm", out_imm, 32'd0);
        in_valid = 1'b0;
        step();
        step();

        // back-pressure: A, B fill the buffer, C waits upstream
        out_ready = 1'b0;
        drive(2'b10, 1'b0, 32'h0000_A000, 21'h000010, 5'd10, 1'b0, 5'd0);
        step();
        drive(2'b10, 1'b1, 32'h0000_B000, 21'h1FFFF0, 5'd11, 1'b0, 5'd0);
        step();
        check_eq("bp_in_ready_low", 32'(in_ready), 32'd0);
        drive(2'b01, 1'b1, 32'h0000_C000, 21'h000123, 5'd12, 1'b0, 5'd0);
        step();
        out_ready = 1'b1;
        push_until_accepted();
        for (int i = 0; i < 4; i++) step();

        // flush while full with an offer pending
        out_ready = 1'b0;
        drive(2'b01, 1'b1, 32'h0000_D000, 21'h000001, 5'd13, 1'b0, 5'd0);
        step();
        drive(2'b01, 1'b1, 32'h0000_D004, 21'h000002, 5'd14, 1'b0, 5'd0);
        step();
        drive(2'b01, 1'b1, 32'h0000_D008, 21'h000003, 5'd15, 1'b0, 5'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_out_valid", 32'(out_valid), 32'd0);
        check_eq("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        step();
        step();

        // random soak
        for (int i = 0; i < 3000; i++) begin
            drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom(),
                  21'($urandom()), 5'($urandom()), 1'($urandom_range(0, 1)), 5'($urandom()));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            step();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_issue_reg.md
# decode_issue_reg

Registered output stage of decode: takes the unified 21-bit immediate, the `use_uj_rd` select and the register fields produced combinationally in decode. It resolves the final destination register and widens the immediate to XLEN per format. It holds the result in a 2-entry skid buffer with a valid/ready handshake toward execute. It also cuts the timing path between the immediate logic and execute, absorbs one cycle of execute back-pressure without a combinational `ready` path, and supports a pipeline flush.

## Interface
- `XLEN`, 32, width of widened immediate and PC
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  discard all buffered entries (branch/exception redirect)
- `in_valid`  in  1  decode presents a valid instruction
- `in_ready`  out  1  stage can accept; function of state only
- `in_group`  in  2  01 R/I, 10 S/B, 11 U/J, 00 illegal
- `in_specifier`  in  1  R/I, S/B, U/J selector (0 = first)
- `in_pc`  in  XLEN  instruction address
- `in_rs1`, `in_rs2`, `in_rd`  in  5 each  register fields from common field split
- `in_uj_rd`  in  5  rd from U/J immediate extractor
- `in_imm`  in  21  unified immediate from decode
- `in_use_uj_rd`  in  1  take rd from `in_uj_rd`
- `out_valid`  out  1  entry available to execute
- `out_ready`  in  1  execute accepts
- `out_group`, `out_specifier`, `out_pc`, `out_rs1`, `out_rs2`  out  2/1/XLEN/5/5  registered copies
- `out_rd`  out  5  resolved destination
- `out_imm`  out  XLEN  widened immediate
- `out_has_imm`  out  1  0 for R-type and illegal, else 1
- `out_illegal`  out  1  captured `in_group == 00`

## Operation
- rd resolve: `rd = in_use_uj_rd ? in_uj_rd : in_rd`; S/B carry rd through but execute ignores it.
- Immediate widening (in front of the main/skid registers):
  - U (11,0): `{in_imm[19:0], 12'b0}`.
  - J (11,1): sign-extend `in_imm[20:0]` to XLEN.
  - I/S/B: sign-extend bit 20 (already sign-extended from bit 11 upstream).
  - R and 00: 0.
- An illegal group is still accepted and forwarded with `out_illegal=1`. The flag is never dropped silently.
- Storage: main register drives the outputs; skid register holds one extra entry.
- States:
  - EMPTY: no entries.
  - ONE: main valid.
  - FULL: main and skid valid.
- `in_ready = (state != FULL)`. `out_valid = (state != EMPTY)`.
- Accept = `in_valid & in_ready`; pop = `out_valid & out_ready`.
- EMPTY: accept → ONE, data into main.
- ONE:
  - accept & pop → ONE, new data into main.
  - accept only → FULL, data into skid.
  - pop only → EMPTY.
- FULL: pop → ONE, skid moves into main; no accept possible.
- `flush` overrides all: next state EMPTY, and any same-cycle accept is discarded.
- Data registers are not cleared on flush or reset; only the valids are.

## Timing
- Reset: state EMPTY. First cycle after reset: `out_valid=0`, `in_ready=1`. All `out_*` data are don't-care while `out_valid=0`, except `out_illegal` and `out_has_imm`, which reset to 0.
- Latency: 1 cycle from accept in EMPTY to `out_valid`.
- Throughput: 1 per cycle while `out_ready=1`.
- Back-pressure: `in_ready` falls in the cycle after the second unpopped entry is captured.
- `in_ready` has no combinational dependence on `out_ready` or `flush`. `out_*` are register outputs only.
- Output data must remain stable while `out_valid & ~out_ready`.
- `flush` during reset: reset dominates, same result.
- Flush in FULL: both entries lost; EMPTY and `in_ready=1` next cycle.

## Structure
- Shared `decode_pkg`:
  - group encodings `GRP_RI=2'b01`, `GRP_SB=2'b10`, `GRP_UJ=2'b11`, `GRP_ILL=2'b00`
  - `IMM_W=21`, `REG_W=5`
  - skid state encoding
- Sub-module `imm_widen`: combinational; takes group, specifier and 21-bit immediate; returns XLEN immediate and `has_imm`. It is reused by the branch-target adder.
- Top keeps the FSM, rd mux, main and skid registers.

## Test plan
- Reset, then I-type: group=01, spec=1, imm=21'h1FFFFF (-1), rd=7, `out_ready=1` → next cycle `out_valid=1`, `out_imm=32'hFFFFFFFF`, `out_rd=7`, `out_has_imm=1`.
- U-type: group=11, spec=0, imm=21'h0ABCDE, use_uj_rd=1, uj_rd=3, rd=9 → `out_imm=32'hABCDE000`, `out_rd=3`.
- J-type: imm=21'h100000 → `out_imm=32'hFFF00000`. R-type: group=01, spec=0 → `out_imm=0`, `out_has_imm=0`.
- Back-pressure: `out_ready=0`, push A, B → `in_ready=0` after B. C held upstream. Raise `out_ready` → A, B, C emerge in order with no loss or duplication; `in_ready` back to 1 one cycle after first pop.
- Flush while FULL with `in_valid=1` same cycle → next cycle `out_valid=0`, `in_ready=1`; the offered entry never appears.
- Illegal group 00 → forwarded with `out_illegal=1`, `out_imm=0`. Random valid/ready and flush soak against a reference queue model.
